// File: rtl/frame_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_burst_arbiter
// Brief    : Arbitrates frame read/write bursts onto one SDRAM controller
//            user port. One burst in flight, round-robin on ties; define
//            ARB_READ_PRIORITY_EN to make read win every tie.
// Revision : 1.0 - initial release
// ============================================================================
module frame_burst_arbiter #(
    parameter int MEM_DATA_BITS = 16,
    parameter int ADDR_BITS     = 24,
    parameter int BURST_BITS    = 10
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,

    input  logic                     rd_burst_req,
    input  logic [BURST_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,

    input  logic                     wr_burst_req,
    input  logic [BURST_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,

    output logic                     sdram_rd_req,
    output logic                     sdram_wr_req,
    output logic [BURST_BITS-1:0]    sdram_len,
    output logic [ADDR_BITS-1:0]     sdram_addr,
    input  logic                     sdram_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] sdram_rd_data,
    input  logic                     sdram_rd_finish,
    input  logic                     sdram_wr_data_req,
    output logic [MEM_DATA_BITS-1:0] sdram_wr_data,
    input  logic                     sdram_wr_finish,

    output logic                     busy,
    output logic                     len_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_WR = 2'd1,
        ST_GNT_RD = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    localparam logic c_LAST_RD = 1'b0;
    localparam logic c_LAST_WR = 1'b1;

    state_t                r_state;
    logic                  r_last_gnt;
    logic                  r_rd_req;
    logic                  r_wr_req;
    logic                  r_busy;
    logic                  r_len_err;
    logic [BURST_BITS-1:0] r_len;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [BURST_BITS:0]   r_cnt;

    logic                  w_in_wr;
    logic                  w_in_rd;
    logic                  w_beat;
    logic                  w_finish;
    logic                  w_pick_wr;
    logic [BURST_BITS:0]   w_cnt_final;

    assign w_in_wr  = (r_state == ST_GNT_WR);
    assign w_in_rd  = (r_state == ST_GNT_RD);

    // Strobes of the side that does not hold the grant are dropped here.
    assign w_beat   = (w_in_wr & sdram_wr_data_req) | (w_in_rd & sdram_rd_valid);
    assign w_finish = (w_in_wr & sdram_wr_finish)   | (w_in_rd & sdram_rd_finish);

    // Beat count including a beat that lands in the finishing cycle.
    assign w_cnt_final = r_cnt + {{BURST_BITS{1'b0}}, w_beat};

    always_comb begin
        w_pick_wr = 1'b0;
`ifdef ARB_READ_PRIORITY_EN
        w_pick_wr = wr_burst_req & ~rd_burst_req;
`else
        w_pick_wr = wr_burst_req & (~rd_burst_req | (r_last_gnt == c_LAST_RD));
`endif
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= c_LAST_RD;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_len_err  <= 1'b0;
            r_len      <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rd_burst_req || wr_burst_req) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (w_pick_wr) begin
                            r_state    <= ST_GNT_WR;
                            r_wr_req   <= 1'b1;
                            r_len      <= wr_burst_len;
                            r_addr     <= wr_burst_addr;
                            r_last_gnt <= c_LAST_WR;
                        end else begin
                            r_state    <= ST_GNT_RD;
                            r_rd_req   <= 1'b1;
                            r_len      <= rd_burst_len;
                            r_addr     <= rd_burst_addr;
                            r_last_gnt <= c_LAST_RD;
                        end
                    end
                end

                ST_GNT_WR, ST_GNT_RD: begin
                    if (w_beat) begin
                        r_cnt <= w_cnt_final;
                    end
                    if (w_finish) begin
                        r_state  <= ST_TURN;
                        r_rd_req <= 1'b0;
                        r_wr_req <= 1'b0;
                        r_busy   <= 1'b0;
                        if (w_cnt_final != {1'b0, r_len}) begin
                            r_len_err <= 1'b1;
                        end
                    end
                end

                // The finished client drops its request during this cycle.
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdram_rd_req        = r_rd_req;
    assign sdram_wr_req        = r_wr_req;
    assign sdram_len           = r_len;
    assign sdram_addr          = r_addr;
    assign busy                = r_busy;
    assign len_err             = r_len_err;

    assign rd_burst_data_valid = w_in_rd & sdram_rd_valid;
    assign rd_burst_finish     = w_in_rd & sdram_rd_finish;
    assign rd_burst_data       = sdram_rd_data;

    assign wr_burst_data_req   = w_in_wr & sdram_wr_data_req;
    assign wr_burst_finish     = w_in_wr & sdram_wr_finish;
    assign sdram_wr_data       = wr_burst_data;

endmodule
`default_nettype wire

// File: tb/tb_frame_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_burst_arbiter
// Brief    : Directed bench for frame_burst_arbiter: burst table plus
//            tie, reset and cross-strobe sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_burst_arbiter;

    logic        mem_clk;
    logic        rst_n;
    logic        rd_burst_req;
    logic [9:0]  rd_burst_len;
    logic [23:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic [15:0] rd_burst_data;
    logic        rd_burst_finish;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [15:0] wr_burst_data;
    logic        wr_burst_finish;
    logic        sdram_rd_req;
    logic        sdram_wr_req;
    logic [9:0]  sdram_len;
    logic [23:0] sdram_addr;
    logic        sdram_rd_valid;
    logic [15:0] sdram_rd_data;
    logic        sdram_rd_finish;
    logic        sdram_wr_data_req;
    logic [15:0] sdram_wr_data;
    logic        sdram_wr_finish;
    logic        busy;
    logic        len_err;

    int n_tests = 0;
    int n_fail  = 0;

    frame_burst_arbiter #(
        .MEM_DATA_BITS(16),
        .ADDR_BITS    (24),
        .BURST_BITS   (10)
    ) dut (
        .mem_clk            (mem_clk),
        .rst_n              (rst_n),
        .rd_burst_req       (rd_burst_req),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data      (rd_burst_data),
        .rd_burst_finish    (rd_burst_finish),
        .wr_burst_req       (wr_burst_req),
        .wr_burst_len       (wr_burst_len),
        .wr_burst_addr      (wr_burst_addr),
        .wr_burst_data_req  (wr_burst_data_req),
        .wr_burst_data      (wr_burst_data),
        .wr_burst_finish    (wr_burst_finish),
        .sdram_rd_req       (sdram_rd_req),
        .sdram_wr_req       (sdram_wr_req),
        .sdram_len          (sdram_len),
        .sdram_addr         (sdram_addr),
        .sdram_rd_valid     (sdram_rd_valid),
        .sdram_rd_data      (sdram_rd_data),
        .sdram_rd_finish    (sdram_rd_finish),
        .sdram_wr_data_req  (sdram_wr_data_req),
        .sdram_wr_data      (sdram_wr_data),
        .sdram_wr_finish    (sdram_wr_finish),
        .busy               (busy),
        .len_err            (len_err)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic        is_wr;
        logic [9:0]  len;
        logic [23:0] addr;
        int          beats;
        logic        exp_err;
    } burst_t;

    burst_t vec [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next falling edge; inputs change here.
    task automatic tick();
        @(negedge mem_clk);
        #1;
    endtask

    function automatic logic tie_exp_wr(input logic alt_wr);
`ifdef ARB_READ_PRIORITY_EN
        return 1'b0;
`else
        return alt_wr;
`endif
    endfunction

    task automatic do_burst(input burst_t b);
        int          fwd;
        logic [15:0] pat;
        fwd = 0;
        tick();
        if (b.is_wr) begin
            wr_burst_req = 1'b1; wr_burst_len = b.len; wr_burst_addr = b.addr;
        end else begin
            rd_burst_req = 1'b1; rd_burst_len = b.len; rd_burst_addr = b.addr;
        end
        #1;
        chk("req_before_edge", {sdram_wr_req, sdram_rd_req}, 2'b00);
        tick();
        chk("grant_req", {sdram_wr_req, sdram_rd_req}, {b.is_wr, ~b.is_wr});
        chk("grant_busy", busy, 1'b1);
        chk("grant_len", sdram_len, b.len);
        chk("grant_addr", sdram_addr, b.addr);
        for (int i = 0; i < b.beats; i++) begin
            pat = 16'(16'h5A00 + i);
            if (b.is_wr) begin
                sdram_wr_data_req = 1'b1; wr_burst_data = pat;
                #1;
                if (wr_burst_data_req) fwd++;
                chk("wr_data_pass", sdram_wr_data, pat);
            end else begin
                sdram_rd_valid = 1'b1; sdram_rd_data = pat;
                #1;
                if (rd_burst_data_valid) fwd++;
                chk("rd_data_pass", rd_burst_data, pat);
            end
            tick();
        end
        sdram_wr_data_req = 1'b0; sdram_rd_valid = 1'b0;
        if (b.is_wr) sdram_wr_finish = 1'b1; else sdram_rd_finish = 1'b1;
        #1;
        chk("finish_fwd", {wr_burst_finish, rd_burst_finish}, {b.is_wr, ~b.is_wr});
        chk("beats_fwd", fwd, b.beats);
        tick();
        sdram_wr_finish = 1'b0; sdram_rd_finish = 1'b0;
        wr_burst_req = 1'b0; rd_burst_req = 1'b0;
        chk("turn_req_low", {sdram_wr_req, sdram_rd_req, busy}, 3'b000);
        tick();
        chk("len_err", len_err, b.exp_err);
    endtask

    // Entered in IDLE with both requests high; one posedge decides the grant.
    task automatic tie_round(input logic exp_wr, input logic reraise);
        tick();
        chk("tie_grant", {sdram_wr_req, sdram_rd_req}, {exp_wr, ~exp_wr});
        chk("tie_addr", sdram_addr, exp_wr ? 24'h0A0000 : 24'h0B0000);
        chk("tie_len", sdram_len, 10'd8);
        for (int i = 0; i < 8; i++) begin
            if (exp_wr) sdram_wr_data_req = 1'b1; else sdram_rd_valid = 1'b1;
            tick();
        end
        sdram_wr_data_req = 1'b0; sdram_rd_valid = 1'b0;
        if (exp_wr) sdram_wr_finish = 1'b1; else sdram_rd_finish = 1'b1;
        tick();
        sdram_wr_finish = 1'b0; sdram_rd_finish = 1'b0;
        if (exp_wr) wr_burst_req = 1'b0; else rd_burst_req = 1'b0;
        if (!reraise) begin
            wr_burst_req = 1'b0; rd_burst_req = 1'b0;
        end
        chk("tie_turn", {sdram_wr_req, sdram_rd_req}, 2'b00);
        tick();
        chk("tie_no_regrant_in_turn", busy, 1'b0);
        if (reraise) begin
            wr_burst_req = 1'b1; rd_burst_req = 1'b1;
        end
    endtask

    initial begin
        vec[0] = '{1'b1, 10'd16, 24'h000100, 16, 1'b0};
        vec[1] = '{1'b0, 10'd16, 24'h123456, 16, 1'b0};
        vec[2] = '{1'b1, 10'd0,  24'hABCDEF, 0,  1'b0};
        vec[3] = '{1'b0, 10'd10, 24'h000040, 9,  1'b1};
        vec[4] = '{1'b1, 10'd8,  24'h000200, 8,  1'b1};
        vec[5] = '{1'b0, 10'd4,  24'h000300, 4,  1'b1};

        rst_n = 1'b0;
        rd_burst_req = 1'b0; rd_burst_len = '0; rd_burst_addr = '0;
        wr_burst_req = 1'b0; wr_burst_len = '0; wr_burst_addr = '0;
        wr_burst_data = '0;
        sdram_rd_valid = 1'b0; sdram_rd_data = '0; sdram_rd_finish = 1'b0;
        sdram_wr_data_req = 1'b0; sdram_wr_finish = 1'b0;
        repeat (3) tick();
        chk("reset_outputs",
            {sdram_rd_req, sdram_wr_req, busy, len_err, rd_burst_data_valid,
             rd_burst_finish, wr_burst_data_req, wr_burst_finish}, 8'h00);
        chk("reset_len_addr", {sdram_len, sdram_addr}, 34'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            do_burst(vec[k]);
        end

        // Reset in the middle of a 32-beat read with a write pending.
        tick();
        rd_burst_req = 1'b1; rd_burst_len = 10'd32; rd_burst_addr = 24'h0C0000;
        tick();
        chk("mid_grant_rd", sdram_rd_req, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sdram_rd_valid = 1'b1;
            tick();
        end
        wr_burst_req = 1'b1; wr_burst_len = 10'd8; wr_burst_addr = 24'h0A0000;
        #1;
        chk("mid_fwd_valid", rd_burst_data_valid, 1'b1);
        chk("mid_err_sticky", len_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {sdram_rd_req, sdram_wr_req, busy, len_err, rd_burst_data_valid,
             rd_burst_finish, wr_burst_data_req, wr_burst_finish}, 8'h00);
        chk("mid_rst_len_addr", {sdram_len, sdram_addr}, 34'h0);
        tick();
        sdram_rd_valid = 1'b0;
        rd_burst_len = 10'd8; rd_burst_addr = 24'h0B0000;
        rst_n = 1'b1;

        // Both requesters held: first tie after reset goes to write.
        tie_round(tie_exp_wr(1'b1), 1'b1);
        tie_round(tie_exp_wr(1'b0), 1'b1);
        tie_round(tie_exp_wr(1'b1), 1'b1);
        tie_round(tie_exp_wr(1'b0), 1'b0);

        // Strobes in IDLE and wrong-type strobes during a read grant.
        sdram_rd_valid = 1'b1; sdram_rd_finish = 1'b1;
        rd_burst_req = 1'b1; rd_burst_len = 10'd4; rd_burst_addr = 24'h0D0000;
        #1;
        chk("idle_strobe_blocked", {rd_burst_data_valid, rd_burst_finish}, 2'b00);
        tick();
        sdram_rd_valid = 1'b0; sdram_rd_finish = 1'b0;
        chk("x_grant_rd", {sdram_wr_req, sdram_rd_req}, 2'b01);
        sdram_wr_data_req = 1'b1; sdram_wr_finish = 1'b1;
        #1;
        chk("x_wr_blocked", {wr_burst_data_req, wr_burst_finish}, 2'b00);
        tick();
        sdram_wr_data_req = 1'b0; sdram_wr_finish = 1'b0;
        chk("x_state_held", {sdram_rd_req, busy}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            sdram_rd_valid = 1'b1;
            tick();
        end
        sdram_rd_finish = 1'b1;
        #1;
        chk("x_finish_fwd", rd_burst_finish, 1'b1);
        tick();
        sdram_rd_valid = 1'b0; sdram_rd_finish = 1'b0; rd_burst_req = 1'b0;
        chk("x_turn", {sdram_rd_req, busy}, 2'b00);
        tick();
        chk("x_len_err_clean", len_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_burst_arbiter.md
# frame_burst_arbiter

Single-clock arbiter between the read channel and the write channel of the frame buffer, which share one SDRAM controller user port. It sits in the `mem_clk` domain:

- Upstream are the frame read/write burst ports (read path feeds the display FIFO, write path drains the camera FIFO).
- Downstream is the SDRAM controller.

It guarantees at most one burst in flight. It selects the winner by round-robin (or read priority), registers the command, and routes the data handshakes to the granted side only. It also checks beat counts against the requested length.

## Interface
Parameters:
- `MEM_DATA_BITS`, 16, data width
- `ADDR_BITS`, 24, burst address width
- `BURST_BITS`, 10, burst length width

Ports:
- `mem_clk` in 1: memory user clock; everything is synchronous to it
- `rst_n` in 1: reset, asynchronous, active-low
- `rd_burst_req` in 1: read client request; held high until its `rd_burst_finish`
- `rd_burst_len` in BURST_BITS: read length in words
- `rd_burst_addr` in ADDR_BITS: read base address
- `rd_burst_data_valid` out 1: gated read data valid
- `rd_burst_data` out MEM_DATA_BITS: read data (pass-through)
- `rd_burst_finish` out 1: gated read finish pulse
- `wr_burst_req` in 1: write client request; held high until its `wr_burst_finish`
- `wr_burst_len` in BURST_BITS: write length in words
- `wr_burst_addr` in ADDR_BITS: write base address
- `wr_burst_data_req` out 1: gated write data request
- `wr_burst_data` in MEM_DATA_BITS: write data
- `wr_burst_finish` out 1: gated write finish pulse
- `sdram_rd_req` out 1: read command to the controller
- `sdram_wr_req` out 1: write command to the controller
- `sdram_len` out BURST_BITS: registered length
- `sdram_addr` out ADDR_BITS: registered address
- `sdram_rd_valid` in 1: read data valid from the controller
- `sdram_rd_data` in MEM_DATA_BITS: read data from the controller
- `sdram_rd_finish` in 1: read finish from the controller
- `sdram_wr_data_req` in 1: write data request from the controller
- `sdram_wr_data` out MEM_DATA_BITS: write data to the controller
- `sdram_wr_finish` in 1: write finish from the controller
- `busy` out 1: a grant is active
- `len_err` out 1: sticky flag, beat count did not match length

## Operation
- States:
  - IDLE: no grant.
  - GNT_WR: write burst granted.
  - GNT_RD: read burst granted.
  - TURN: one-cycle gap after each burst.
- IDLE:
  - Only `wr_burst_req` high → GNT_WR.
  - Only `rd_burst_req` high → GNT_RD.
  - Both high → the side not granted last (`last_gnt` register; reset value = RD, so the first tie goes to write).
  - Neither high → stay in IDLE.
- On entering a grant state:
  - `sdram_len`/`sdram_addr` load from the winner.
  - The matching `sdram_*_req` goes high.
  - `last_gnt` updates.
  - The beat counter (BURST_BITS+1 wide) clears.
- GNT_WR:
  - `wr_burst_data_req` = `sdram_wr_data_req`.
  - `sdram_wr_data` = `wr_burst_data` (combinational).
  - The counter increments on each `sdram_wr_data_req`.
- GNT_RD:
  - `rd_burst_data_valid` = `sdram_rd_valid`; `rd_burst_data` = `sdram_rd_data`.
  - The counter increments on each valid.
- Finish:
  - `sdram_*_finish` of the granted type passes combinationally to the client.
  - On that edge: state → TURN, `sdram_*_req` drops.
  - If counter (including the finishing-cycle beat) ≠ `sdram_len`, `len_err` sets.
- Finish of the non-granted type, or strobes in IDLE/TURN: ignored, never forwarded, no counting.
- TURN: requests ignored (the client drops its req during this cycle) → IDLE.
- `sdram_len` = 0: granted normally; finish with zero beats, no error.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs 0; `sdram_len`/`sdram_addr` 0.
  - `last_gnt` = RD; `len_err` 0.
- Reset mid-burst: everything above clears asynchronously. The controller shares `rst_n`.
- Grant latency: request sampled high in IDLE at edge n → `sdram_*_req` and `busy` high after edge n.
- Finish:
  - Forwarded in the same cycle.
  - `sdram_*_req` low after that edge.
  - The next grant is possible at the earliest two edges after finish (TURN, then IDLE).
- Back-to-back requests from the same sole requester: one burst per minimum 1 + L + 2 cycles, where L = controller latency.
- `sdram_wr_data_req` is one cycle ahead of data. The arbiter adds no delay to data paths.

## Configuration
- `ARB_READ_PRIORITY_EN` defined: on a tie in IDLE, read always wins (protects display underflow). `last_gnt` is still maintained but unused.
- Undefined: strict alternation on ties as above.

## Test plan
- Write req only, len 16; controller issues 16 data_req then finish → `sdram_wr_req` rises 1 cycle after req, 16 `wr_burst_data_req` forwarded, finish forwarded, `len_err` 0.
- Both reqs held continuously, len 8 each, macro off → grants alternate W,R,W,R, each separated by one TURN cycle. Macro on → R every time while read req is held.
- Read grant active; inject `sdram_wr_data_req` and `sdram_wr_finish` → nothing forwarded to the write client, state unchanged.
- len 10, controller gives 9 valids then finish → `len_err` = 1, and it stays 1 through later correct bursts.
- Deassert `rst_n` mid-read burst (beat 5 of 32) → all outputs 0 immediately, state IDLE. After release, a pending write is granted first (`last_gnt` = RD).
- len 0 write → grant, finish with 0 beats, `len_err` 0.
